// File: rtl/data_memory_banked.sv
// rtl/data_memory_banked.sv - byte-enabled single-port data memory with optional zero-fill (DMEM_CLEAR_EN)
// Reads return registered data one cycle after acceptance; out-of-range requests flag addr_err.
module data_memory_banked #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   mem_address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic                    write_en,
    input  logic                    read_en,
    output logic                    ready,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    rd_valid,
    output logic                    addr_err
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic             ready_q;
    logic             in_range;
    logic             wr_acc;
    logic             rd_acc;
    logic [IDX_W-1:0] idx;

    assign ready    = ready_q;
    assign in_range = ({1'b0, mem_address} < (ADDR_WIDTH+1)'(DEPTH));
    assign idx      = mem_address[IDX_W-1:0];
    // A simultaneous read is dropped so the write owns the port.
    assign wr_acc   = ready_q & write_en;
    assign rd_acc   = ready_q & read_en & ~write_en;

`ifdef DMEM_CLEAR_EN
    typedef enum logic {CLEAR, READY} state_t;

    state_t           state;
    logic [IDX_W-1:0] clr_cnt;
    logic             clr_wr;

    // Gated with rst so an asserted reset never touches the array.
    assign clr_wr = (state == CLEAR) & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_cnt == IDX_W'(DEPTH - 1)) begin
                        state   <= READY;
                        ready_q <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                READY: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= CLEAR;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[clr_cnt] <= '0;
        end else if (wr_acc && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (byte_en[b]) begin
                    mem[idx][8*b +: 8] <= data_in[8*b +: 8];
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (byte_en[b]) begin
                    mem[idx][8*b +: 8] <= data_in[8*b +: 8];
                end
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            addr_err <= (wr_acc | rd_acc) & ~in_range;
            if (rd_acc) begin
                data_out <= in_range ? mem[idx] : '0;
            end
        end
    end

endmodule

// File: doc/data_memory_banked.md
DATA_MEMORY_BANKED -- requirements
Module: data_memory_banked

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter DATA_WIDTH, default 64, word width in bits; SHALL be a multiple of 8.
REQ-003 Parameter ADDR_WIDTH, default 8, address width in bits.
REQ-004 Parameter DEPTH, default 256, number of words; SHALL be at most 2**ADDR_WIDTH.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 mem_address  input  ADDR_WIDTH  word address for the current request.
REQ-008 data_in  input  DATA_WIDTH  write data.
REQ-009 byte_en  input  DATA_WIDTH/8  per-byte write enable; bit i covers data_in[8i+7:8i].
REQ-010 write_en  input  1  write request.
REQ-011 read_en  input  1  read request.
REQ-012 ready  output  1  high when a request presented this cycle will be accepted.
REQ-013 data_out  output  DATA_WIDTH  read data.
REQ-014 rd_valid  output  1  one-cycle pulse: data_out holds a new read result.
REQ-015 addr_err  output  1  one-cycle pulse: the accepted request had mem_address >= DEPTH.

Function
REQ-016 A request SHALL be accepted only on a rising edge where ready=1 and write_en or read_en is high; when ready=0, requests SHALL be ignored with no side effects.
REQ-017 An accepted write SHALL update only the bytes whose byte_en bit is 1; all other bytes SHALL keep their value.
REQ-018 byte_en=0 on an accepted write SHALL leave memory unchanged and SHALL NOT raise addr_err unless the address is out of range.
REQ-019 An accepted read SHALL drive data_out and pulse rd_valid exactly one cycle after acceptance (latency 1).
REQ-020 data_out SHALL hold its last value until the next accepted read.
REQ-021 If write_en and read_en are both high, the write SHALL win, the read SHALL be dropped, and rd_valid SHALL stay 0.
REQ-022 A read accepted in the cycle after a write to the same address SHALL return the newly written data.
REQ-023 An out-of-range write SHALL be discarded, and addr_err SHALL pulse one cycle later.
REQ-024 An out-of-range read SHALL return all-zero data_out, and rd_valid and addr_err SHALL both pulse one cycle later.
REQ-025 Control state machine states: CLEAR, READY.
- ready=1 only in READY.
- CLEAR -> READY when the clear counter reaches DEPTH-1; the final word is written in that cycle.
- READY is held until reset.

Reset
REQ-026 Asserting rst (low) SHALL immediately drive rd_valid=0, addr_err=0 and data_out=0, and SHALL set the clear counter to 0.
REQ-027 With DMEM_CLEAR_EN defined, reset SHALL enter CLEAR and drive ready=0; otherwise it SHALL enter READY and drive ready=1 after deassertion.
REQ-028 Reset asserted mid-clear SHALL restart the clear from word 0 after deassertion.
REQ-029 Memory contents SHALL NOT be changed by reset itself.

Configuration
REQ-030 Macro DMEM_CLEAR_EN SHALL control the clear engine.
- Defined: after reset the block SHALL write zero to words 0..DEPTH-1, one word per cycle in ascending order, and then enter READY; ready SHALL rise exactly DEPTH cycles after reset deassertion.
- Not defined: the CLEAR state and counter SHALL be absent, memory contents after power-up SHALL be undefined, and ready SHALL be 1 from the first edge after deassertion.

Verification
REQ-031 DMEM_CLEAR_EN defined, DEPTH=256: write 64'hFF at address 5, then release reset and read address 5 -> ready rises 256 cycles after deassertion; the read returns 0.
REQ-032 Write 64'h1122334455667788 to address 3 with byte_en=8'hFF, then write 64'hAAAAAAAAAAAAAAAA with byte_en=8'h0F, then read address 3 -> data_out=64'h11223344AAAAAAAA, with rd_valid high exactly one cycle after the read.
REQ-033 DEPTH=200: write to address 210, then read address 210 -> addr_err pulses after each; the read returns 0 with rd_valid=1; memory is unchanged.
REQ-034 write_en=1 and read_en=1 at address 7 with data 64'h5 -> word 7 becomes 5; rd_valid stays 0; the next read of address 7 returns 5.
REQ-035 Back-to-back write 64'h9 to address 1, then read address 1 on the next cycle -> data_out=64'h9.
REQ-036 Assert rst at clear count 100, hold 3 cycles, release -> ready rises 256 cycles after the release, and all words read 0.
